// File: rtl/asrm_uart_bus_master_if.sv
// System-bus side of the UART debug initiator.
// Ports: bus_addr, bus_write_en, bus_data_out, bus_active (master out), bus_data_in (slave out).
interface asrm_uart_bus_master_if #(
    parameter int word_size = 16,
    parameter int addr_size = 16
);
    logic [addr_size-1:0] bus_addr;
    logic                 bus_write_en;
    logic [word_size-1:0] bus_data_out;
    logic [word_size-1:0] bus_data_in;
    logic                 bus_active;

    modport master (
        output bus_addr,
        output bus_write_en,
        output bus_data_out,
        output bus_active,
        input  bus_data_in
    );

    modport slave (
        input  bus_addr,
        input  bus_write_en,
        input  bus_data_out,
        input  bus_active,
        output bus_data_in
    );
endinterface

// File: rtl/asrm_uart_bus_master.sv
// UART (8N1) debug bus master: 'W' addr data -> write + 0x06, 'R' addr -> read data.
// Ports: clk, reset (sync, active-low), rx, tx, frame_error, bus (master modport).
module asrm_uart_bus_master #(
    parameter int word_size = 16,
    parameter int addr_size = 16,
    parameter int clk_freq  = 1000000,
    parameter int baud      = 9600
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    output logic frame_error,
    asrm_uart_bus_master_if.master bus
);
    localparam int DIV  = clk_freq / (baud * 16);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AB   = addr_size / 8;
    localparam int WB   = word_size / 8;
    localparam int MAXB = (AB > WB) ? AB : WB;
    localparam int IDXW = $clog2(MAXB + 1);

    localparam logic [word_size-1:0] ACK_W = word_size'(8'h06) << (word_size - 8);
    localparam logic [word_size-1:0] NAK_W = word_size'(8'h15) << (word_size - 8);

    // 16x oversample tick
    logic [DIVW-1:0] div_cnt;
    logic            tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIVW'(DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIVW'(1);
            tick    <= 1'b0;
        end
    end

    // receiver
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t rx_st;
    logic       rx_m, rx_s, rx_p;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bcnt;
    logic [7:0] rx_sh;
    logic       byte_valid;
    logic       rx_ferr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_p       <= 1'b1;
            rx_st      <= RX_IDLE;
            rx_tcnt    <= '0;
            rx_bcnt    <= '0;
            rx_sh      <= '0;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            rx_p       <= rx_s;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_p && !rx_s) begin
                        rx_st   <= RX_START;
                        rx_tcnt <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        // mid start bit: a high line means it was a glitch
                        if (rx_tcnt == 4'd7) begin
                            rx_tcnt <= '0;
                            rx_bcnt <= '0;
                            rx_st   <= rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            rx_sh   <= {rx_s, rx_sh[7:1]};
                            rx_bcnt <= rx_bcnt + 3'd1;
                            if (rx_bcnt == 3'd7) rx_st <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                        if (rx_tcnt == 4'd15) begin
                            byte_valid <= rx_s;
                            rx_ferr    <= !rx_s;
                            rx_st      <= RX_IDLE;
                        end
                    end
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // transmitter
    logic       tx_busy;
    logic [8:0] tx_sh;
    logic [3:0] tx_tcnt;
    logic [3:0] tx_bcnt;
    logic       tx_load;
    logic [7:0] tx_byte;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_tcnt <= '0;
            tx_bcnt <= '0;
        end else if (!tx_busy) begin
            if (tx_load) begin
                tx      <= 1'b0;
                tx_sh   <= {1'b1, tx_byte};
                tx_tcnt <= '0;
                tx_bcnt <= '0;
                tx_busy <= 1'b1;
            end
        end else if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
                // bit 9 is the stop bit; busy drops once it has been held
                if (tx_bcnt == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx      <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[8:1]};
                    tx_bcnt <= tx_bcnt + 4'd1;
                end
            end
        end
    end

    // command FSM
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_WR, BUS_RD, REPLY} state_t;

    state_t               st;
    logic                 is_wr;
    logic [IDXW-1:0]      idx;
    logic [addr_size-1:0] addr_reg;
    logic [word_size-1:0] data_reg;
    logic [word_size-1:0] reply_sh;
    logic [IDXW-1:0]      reply_cnt;
    logic                 rd_cnt;

    assign tx_load = (st == REPLY) && !tx_busy;
    assign tx_byte = reply_sh[word_size-1 -: 8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            st               <= IDLE;
            is_wr            <= 1'b0;
            idx              <= '0;
            addr_reg         <= '0;
            data_reg         <= '0;
            reply_sh         <= '0;
            reply_cnt        <= '0;
            rd_cnt           <= 1'b0;
            frame_error      <= 1'b0;
            bus.bus_addr     <= '0;
            bus.bus_write_en <= 1'b0;
            bus.bus_data_out <= '0;
            bus.bus_active   <= 1'b0;
        end else begin
            frame_error      <= rx_ferr;
            bus.bus_write_en <= 1'b0;
            case (st)
                IDLE: begin
                    if (byte_valid) begin
                        idx <= '0;
                        if (rx_sh == 8'h57) begin
                            is_wr <= 1'b1;
                            st    <= ADDR;
                        end else if (rx_sh == 8'h52) begin
                            is_wr <= 1'b0;
                            st    <= ADDR;
                        end else begin
                            frame_error <= 1'b1;
                            reply_sh    <= NAK_W;
                            reply_cnt   <= IDXW'(1);
                            st          <= REPLY;
                        end
                    end
                end
                ADDR: begin
                    if (rx_ferr) begin
                        reply_sh  <= NAK_W;
                        reply_cnt <= IDXW'(1);
                        st        <= REPLY;
                    end else if (byte_valid) begin
                        addr_reg <= addr_size'({addr_reg, rx_sh});
                        idx      <= idx + IDXW'(1);
                        if (idx == IDXW'(AB - 1)) begin
                            idx <= '0;
                            if (is_wr) begin
                                st <= WDATA;
                            end else begin
                                bus.bus_addr   <= addr_size'({addr_reg, rx_sh});
                                bus.bus_active <= 1'b1;
                                rd_cnt         <= 1'b0;
                                st             <= BUS_RD;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rx_ferr) begin
                        reply_sh  <= NAK_W;
                        reply_cnt <= IDXW'(1);
                        st        <= REPLY;
                    end else if (byte_valid) begin
                        data_reg <= word_size'({data_reg, rx_sh});
                        idx      <= idx + IDXW'(1);
                        if (idx == IDXW'(WB - 1)) begin
                            bus.bus_addr     <= addr_reg;
                            bus.bus_data_out <= word_size'({data_reg, rx_sh});
                            bus.bus_write_en <= 1'b1;
                            bus.bus_active   <= 1'b1;
                            st               <= BUS_WR;
                        end
                    end
                end
                BUS_WR: begin
                    bus.bus_active <= 1'b0;
                    reply_sh       <= ACK_W;
                    reply_cnt      <= IDXW'(1);
                    st             <= REPLY;
                end
                BUS_RD: begin
                    // second clk: peripherals' registered read data is valid
                    rd_cnt <= 1'b1;
                    if (rd_cnt) begin
                        reply_sh       <= bus.bus_data_in;
                        reply_cnt      <= IDXW'(WB);
                        bus.bus_active <= 1'b0;
                        st             <= REPLY;
                    end
                end
                REPLY: begin
                    if (tx_load) begin
                        reply_sh  <= reply_sh << 8;
                        reply_cnt <= reply_cnt - IDXW'(1);
                        if (reply_cnt == IDXW'(1)) st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asrm_uart_bus_master.sv
// Bench for asrm_uart_bus_master: UART host driver, tx decoder, bus peripheral and
// a host-level model of expected strobes and replies.
`timescale 1ns/1ps
module tb_asrm_uart_bus_master;
    localparam int W   = 16;
    localparam int A   = 16;
    localparam int CF  = 1536000;
    localparam int BD  = 9600;
    localparam int BIT = 160;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic tx;
    logic frame_error;

    asrm_uart_bus_master_if #(.word_size(W), .addr_size(A)) bif ();

    asrm_uart_bus_master #(
        .word_size(W), .addr_size(A), .clk_freq(CF), .baud(BD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .tx(tx),
        .frame_error(frame_error),
        .bus(bif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // peripheral with registered read
    logic [15:0] pmem [logic [15:0]];

    function automatic logic [15:0] prd(input logic [15:0] a);
        return pmem.exists(a) ? pmem[a] : (a ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        bif.bus_data_in <= prd(bif.bus_addr);
        if (bif.bus_write_en) pmem[bif.bus_addr] = bif.bus_data_out;
    end

    // reference: what the host believes memory holds
    logic [15:0] mdl [logic [15:0]];

    function automatic logic [15:0] exp_rd(input logic [15:0] a);
        return mdl.exists(a) ? mdl[a] : (a ^ 16'h5A5A);
    endfunction

    // bus observer
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t wq[$];
    int act_cnt = 0;
    int fe_cnt = 0;
    int we_out = 0;

    always @(negedge clk) begin
        if (bif.bus_active === 1'b1) act_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (bif.bus_write_en === 1'b1) begin
            wq.push_back({bif.bus_addr, bif.bus_data_out});
            if (bif.bus_active !== 1'b1) we_out++;
        end
    end

    // tx decoder
    logic [7:0] txq[$];

    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge tx);
            repeat (BIT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            txq.push_back(b);
        end
    end

    task automatic send(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stopb;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge clk);
    endtask

    task automatic send_wr(input logic [15:0] a, input logic [15:0] d);
        send(8'h57, 1'b1);
        send(a[15:8], 1'b1);
        send(a[7:0], 1'b1);
        send(d[15:8], 1'b1);
        send(d[7:0], 1'b1);
        mdl[a] = d;
    endtask

    task automatic send_rd(input logic [15:0] a);
        send(8'h52, 1'b1);
        send(a[15:8], 1'b1);
        send(a[7:0], 1'b1);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int t;
        t = 0;
        while (txq.size() < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, txq.size(), n);
    endtask

    task automatic pop_tx(input string tag, input logic [7:0] exp);
        logic [7:0] v;
        v = 8'hxx;
        if (txq.size() > 0) v = txq.pop_front();
        chk(tag, {24'h0, v}, {24'h0, exp});
    endtask

    task automatic pop_wr(input string tag, input logic [15:0] a,
                          input logic [15:0] d);
        wr_t w;
        w = 'x;
        if (wq.size() > 0) w = wq.pop_front();
        chk({tag, "_addr"}, {16'h0, w.a}, {16'h0, a});
        chk({tag, "_data"}, {16'h0, w.d}, {16'h0, d});
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        int a0, w0;
        logic [15:0] e;
        a0 = act_cnt;
        w0 = wq.size();
        e = exp_rd(a);
        send_rd(a);
        wait_tx(2, {tag, "_n"});
        pop_tx({tag, "_hi"}, e[15:8]);
        pop_tx({tag, "_lo"}, e[7:0]);
        chk({tag, "_act"}, act_cnt - a0, 2);
        chk({tag, "_nowr"}, wq.size(), w0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int a0, f0, t, k;

    initial begin
        pmem[16'hFF05] = 16'hA5C3;
        mdl[16'hFF05] = 16'hA5C3;

        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_we", bif.bus_write_en, 0);
        chk("rst_dout", bif.bus_data_out, 0);
        chk("rst_act", bif.bus_active, 0);
        chk("rst_fe", frame_error, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // single write
        a0 = act_cnt;
        send_wr(16'h1234, 16'hBEEF);
        chk("wr_n", wq.size(), 1);
        pop_wr("wr", 16'h1234, 16'hBEEF);
        chk("wr_act", act_cnt - a0, 1);
        wait_tx(1, "wr_ack_n");
        pop_tx("wr_ack", 8'h06);

        // read with registered peripheral
        do_read(16'hFF05, "rd");

        // unknown command
        a0 = act_cnt;
        f0 = fe_cnt;
        send(8'h41, 1'b1);
        wait_tx(1, "nak_n");
        pop_tx("nak", 8'h15);
        chk("nak_fe", fe_cnt - f0, 1);
        chk("nak_act", act_cnt - a0, 0);

        // short low glitch is not a byte
        f0 = fe_cnt;
        a0 = act_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_fe", fe_cnt - f0, 0);
        chk("glitch_tx", txq.size(), 0);

        // bad stop bit on a command byte
        send(8'h57, 1'b0);
        repeat (50) @(negedge clk);
        chk("stop_fe", fe_cnt - f0, 1);
        chk("stop_tx", txq.size(), 0);
        chk("stop_act", act_cnt - a0, 0);
        do_read(16'h0000, "rd0");

        // reset in the middle of an address byte
        send(8'h57, 1'b1);
        rx = 1'b0;
        repeat (2 * BIT + $urandom_range(0, 3 * BIT)) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rsta_tx", tx, 1);
        chk("rsta_act", bif.bus_active, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // reset in the middle of a read reply
        send_rd(16'($urandom));
        t = 0;
        while (tx !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("rstr_start", tx, 0);
        repeat ($urandom_range(200, 1400)) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstr_tx", tx, 1);
        chk("rstr_act", bif.bus_active, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (1800) @(negedge clk);
        chk("rstr_quiet", tx, 1);
        txq.delete();
        wq.delete();

        // back-to-back writes
        a0 = act_cnt;
        for (int i = 0; i < 5; i++) send_wr(16'(i), 16'(i + 1));
        chk("b2b_n", wq.size(), 5);
        for (int i = 0; i < 5; i++) pop_wr($sformatf("b2b%0d", i), 16'(i), 16'(i + 1));
        chk("b2b_act", act_cnt - a0, 5);
        wait_tx(5, "b2b_ack_n");
        for (int i = 0; i < 5; i++) pop_tx($sformatf("b2b_ack%0d", i), 8'h06);

        // random read-back of one of them
        k = $urandom_range(0, 4);
        do_read(16'(k), "rdback");

        chk("we_outside", we_out, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
